i2c_reg_file: RTL and testbench
===============================

Name: i2c_reg_file

Overview:
Parametrised CPU-side register file for the I2C master, the successor to the fixed 8-bit register block. It decodes single-cycle bus accesses into prescaler, command, address/RW, transmit, receive, status, mask and level registers. Transmit writes generate TX-FIFO push strobes and receive reads generate RX-FIFO pop strobes. Core event pulses are captured as sticky status bits, and a maskable interrupt is produced. It sits between the APB slave and the I2C core and FIFOs.

Parameters:
DATA_W, 8, bus and register data width; must be at least 8.
ADDR_W, 8, register address width.
PRESC_W, 16, prescaler width; must lie in DATA_W+1..2*DATA_W and spans two registers.
PRESC_RST, 249, prescaler reset value.
NUM_EVT, DATA_W-2, number of core event inputs; this is a localparam, not overridable.

Ports:
CLOCK_i  in  1  block clock
RESET_i  in  1  asynchronous, active-low reset
SEL_i  in  1  one-cycle access strobe
PWRITE_i  in  1  1 = write, 0 = read; sampled with SEL_i
REGISTER_ADDR_i  in  ADDR_W  register offset
DATA_i  in  DATA_W  write data
RDATA_o  out  DATA_W  read data
READY_o  out  1  access-complete pulse
SLVERR_o  out  1  error flag, qualified by READY_o
RECEIVE_i  in  DATA_W  RX FIFO head data
RX_EMPTY_i  in  1  RX FIFO empty
TX_FULL_i  in  1  TX FIFO full
RX_POP_o  out  1  RX FIFO pop pulse
TX_PUSH_o  out  1  TX FIFO push pulse
TRANSMIT_o  out  DATA_W  TX FIFO write data
STATUS_EVT_i  in  NUM_EVT  event pulses from the core
BUSY_i  in  1  core transfer in progress
PRESCALER_o  out  PRESC_W  SCL divider value
ADDRESS_RW_o  out  DATA_W  slave address in [7:1], RW in [0]
CMD_START_o  out  1  start request pulse
CMD_STOP_o  out  1  stop request pulse
IRQ_o  out  1  interrupt, level

Behaviour:
- Register map:
  - 0x00 PRESC_LO, read/write.
  - 0x01 PRESC_HI, read/write. Bits at or above PRESC_W are ignored on write and read as 0.
  - 0x02 CMD, write: [0] START, [1] STOP, [2] IRQ_EN. Read returns only [2].
  - 0x03 ADDRESS_RW, read/write.
  - 0x04 TRANSMIT, write-only. Read returns 0.
  - 0x05 RECEIVE, read-only. Read pops the RX FIFO.
  - 0x06 STATUS, read; write-1-to-clear.
    - [NUM_EVT-1:0] are sticky core events.
    - [DATA_W-2] is TX_OVF.
    - [DATA_W-1] is RX_UDF.
  - 0x07 IRQ_MASK, read/write.
  - 0x08 LEVEL, read-only: [0] BUSY_i, [1] RX_EMPTY_i, [2] TX_FULL_i.
- Access timing:
  - An access is taken in a cycle with SEL_i=1.
  - READY_o, SLVERR_o and RDATA_o are registered and valid exactly one cycle later.
  - Back-to-back SEL_i on every cycle is legal.
  - RDATA_o holds its value between accesses.
- SLVERR=1, with no state change, in these cases:
  - unmapped address;
  - write to a read-only register (write to STATUS is legal);
  - write to PRESC_LO, PRESC_HI or ADDRESS_RW while BUSY_i=1.
- Command register:
  - A START write with BUSY_i=0 gives a one-cycle CMD_START_o pulse in the READY cycle.
  - A START write with BUSY_i=1 is ignored and returns SLVERR. IRQ_EN is still updated.
  - STOP always gives a one-cycle CMD_STOP_o pulse.
  - START and STOP written together: STOP only.
- Transmit:
  - A TRANSMIT write with TX_FULL_i=0 registers DATA_i onto TRANSMIT_o and gives a one-cycle TX_PUSH_o pulse, both in the READY cycle.
  - A TRANSMIT write with TX_FULL_i=1 gives no push, returns SLVERR and sets TX_OVF.
- Receive:
  - A RECEIVE read with RX_EMPTY_i=0 returns RECEIVE_i sampled at the access cycle, with a one-cycle RX_POP_o pulse in the READY cycle.
  - A RECEIVE read with RX_EMPTY_i=1 returns 0, gives no pop, returns SLVERR and sets RX_UDF.
- Status:
  - Any cycle with STATUS_EVT_i[k]=1 sets the corresponding bit.
  - A write of 1 clears the bit.
  - A set and a clear of the same bit in the same cycle: set wins.
- Interrupt: IRQ_o is registered and equals IRQ_EN & |(STATUS & IRQ_MASK). It updates one cycle after any change to its inputs.
- Reset (RESET_i=0, asynchronous, any time including mid-access):
  - PRESCALER_o = PRESC_RST.
  - All other registers and outputs are 0.
  - Any pending pulse and READY_o are dropped immediately.
  - An access in flight when reset asserts is lost and no READY_o is issued.

Decomposition:
- Shared package i2c_reg_pkg holds:
  - register offset constants (ADDR_PRESC_LO .. ADDR_LEVEL);
  - CMD bit positions;
  - STATUS bit positions for TX_OVF and RX_UDF;
  - LEVEL bit positions.
- One sub-module, i2c_sticky_status: per-bit set/W1C/set-wins logic plus the IRQ reduction, parametrised by DATA_W.

Test Plan:
- Reset released, read 0x00, 0x01 and 0x06 -> RDATA 0xF9, 0x00 and 0x00; SLVERR=0; IRQ_o=0.
- Write 0x04=0xA5 with TX_FULL_i=0, then with TX_FULL_i=1 -> first: TX_PUSH_o for one cycle, TRANSMIT_o=0xA5. Second: no push, SLVERR=1, STATUS[6]=1.
- RECEIVE_i=0x3C, RX_EMPTY_i=0, read 0x05 -> RDATA 0x3C with one RX_POP_o pulse. With RX_EMPTY_i=1 -> RDATA 0, SLVERR=1, STATUS[7]=1.
- Write CMD=0x01 with BUSY_i=1 -> no CMD_START_o, SLVERR=1. With BUSY_i=0 -> one-cycle CMD_START_o. Write CMD=0x03 -> CMD_STOP_o only.
- Mask=0x01 and CMD=0x04, pulse STATUS_EVT_i[0] -> IRQ_o=1. Write 0x06=0x01 in the same cycle as a new EVT[0] pulse -> the bit stays 1. Next W1C clears it -> IRQ_o=0.
- Set PRESC_HI=0x12 with BUSY_i=0 -> PRESCALER_o=0x12F9. Assert RESET_i=0 mid-access -> PRESCALER_o=249 immediately and no READY_o.

Source files
------------

// File: rtl/i2c_reg_pkg.sv
// Shared constants for the I2C master register file.
//   - Register offsets (ADDR_PRESC_LO .. ADDR_LEVEL)
//   - CMD register bit positions
//   - STATUS bit positions for TX_OVF / RX_UDF (relative to the data width)
//   - LEVEL register bit positions
package i2c_reg_pkg;

    localparam int unsigned ADDR_PRESC_LO = 0;
    localparam int unsigned ADDR_PRESC_HI = 1;
    localparam int unsigned ADDR_CMD      = 2;
    localparam int unsigned ADDR_ADDR_RW  = 3;
    localparam int unsigned ADDR_TRANSMIT = 4;
    localparam int unsigned ADDR_RECEIVE  = 5;
    localparam int unsigned ADDR_STATUS   = 6;
    localparam int unsigned ADDR_IRQ_MASK = 7;
    localparam int unsigned ADDR_LEVEL    = 8;

    localparam int CMD_START_BIT  = 0;
    localparam int CMD_STOP_BIT   = 1;
    localparam int CMD_IRQ_EN_BIT = 2;

    localparam int LVL_BUSY_BIT     = 0;
    localparam int LVL_RX_EMPTY_BIT = 1;
    localparam int LVL_TX_FULL_BIT  = 2;

    // The two error flags occupy the top two STATUS bits; the core events
    // fill everything below them.
    function automatic int stat_tx_ovf_bit(input int data_w);
        return data_w - 2;
    endfunction

    function automatic int stat_rx_udf_bit(input int data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/i2c_sticky_status.sv
// Sticky status register with write-1-to-clear and a registered, maskable
// interrupt.
//   clk, rst_n : clock, asynchronous active-low reset
//   evt_set    : per-bit set pulses (set wins over a simultaneous clear)
//   w1c        : per-bit clear strobes from a STATUS write
//   mask       : interrupt mask
//   irq_en     : global interrupt enable
//   status     : current sticky bits
//   irq        : irq_en & |(status & mask), one cycle behind its inputs
module i2c_sticky_status #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] evt_set,
    input  logic [DATA_W-1:0] w1c,
    input  logic [DATA_W-1:0] mask,
    input  logic              irq_en,
    output logic [DATA_W-1:0] status,
    output logic              irq
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
            irq    <= 1'b0;
        end else begin
            // Clear first, then OR in the sets so a same-cycle set survives.
            status <= (status & ~w1c) | evt_set;
            irq    <= irq_en & |(status & mask);
        end
    end

endmodule

// File: rtl/i2c_reg_file.sv
// CPU-side register file for the I2C master.
//   CLOCK_i / RESET_i            : clock, asynchronous active-low reset
//   SEL_i, PWRITE_i, REGISTER_ADDR_i, DATA_i : single-cycle access request
//   RDATA_o, READY_o, SLVERR_o   : registered response, one cycle after SEL_i
//   RECEIVE_i, RX_EMPTY_i, RX_POP_o          : RX FIFO head / pop
//   TX_FULL_i, TX_PUSH_o, TRANSMIT_o         : TX FIFO push
//   STATUS_EVT_i, BUSY_i         : core event pulses and busy level
//   PRESCALER_o, ADDRESS_RW_o    : configuration to the core
//   CMD_START_o, CMD_STOP_o      : command pulses
//   IRQ_o                        : level interrupt
module i2c_reg_file
    import i2c_reg_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int PRESC_W   = 16,
    parameter int PRESC_RST = 249
) (
    input  logic               CLOCK_i,
    input  logic               RESET_i,
    input  logic               SEL_i,
    input  logic               PWRITE_i,
    input  logic [ADDR_W-1:0]  REGISTER_ADDR_i,
    input  logic [DATA_W-1:0]  DATA_i,
    output logic [DATA_W-1:0]  RDATA_o,
    output logic               READY_o,
    output logic               SLVERR_o,
    input  logic [DATA_W-1:0]  RECEIVE_i,
    input  logic               RX_EMPTY_i,
    input  logic               TX_FULL_i,
    output logic               RX_POP_o,
    output logic               TX_PUSH_o,
    output logic [DATA_W-1:0]  TRANSMIT_o,
    input  logic [DATA_W-3:0]  STATUS_EVT_i,
    input  logic               BUSY_i,
    output logic [PRESC_W-1:0] PRESCALER_o,
    output logic [DATA_W-1:0]  ADDRESS_RW_o,
    output logic               CMD_START_o,
    output logic               CMD_STOP_o,
    output logic               IRQ_o
);

    localparam int NUM_EVT    = DATA_W - 2;
    localparam int HI_W       = PRESC_W - DATA_W;
    localparam int STAT_OVF   = stat_tx_ovf_bit(DATA_W);
    localparam int STAT_UDF   = stat_rx_udf_bit(DATA_W);

    logic [PRESC_W-1:0] presc_q;
    logic [DATA_W-1:0]  mask_q;
    logic               irq_en_q;
    logic [DATA_W-1:0]  status;

    // Decoded per-access actions
    logic              err;
    logic [DATA_W-1:0] rdata_nxt;
    logic              presc_lo_we, presc_hi_we, addr_rw_we, cmd_we, mask_we;
    logic              tx_push, rx_pop, start, stop;
    logic              tx_ovf_set, rx_udf_set;
    logic [DATA_W-1:0] stat_w1c, stat_set;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        err         = 1'b0;
        rdata_nxt   = '0;
        presc_lo_we = 1'b0;
        presc_hi_we = 1'b0;
        addr_rw_we  = 1'b0;
        cmd_we      = 1'b0;
        mask_we     = 1'b0;
        tx_push     = 1'b0;
        rx_pop      = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        tx_ovf_set  = 1'b0;
        rx_udf_set  = 1'b0;
        stat_w1c    = '0;

        if (SEL_i) begin
            case (REGISTER_ADDR_i)
                ADDR_W'(ADDR_PRESC_LO): begin
                    if (!PWRITE_i)   rdata_nxt   = presc_q[DATA_W-1:0];
                    else if (BUSY_i) err         = 1'b1;
                    else             presc_lo_we = 1'b1;
                end
                ADDR_W'(ADDR_PRESC_HI): begin
                    // Shift leaves only the upper prescaler bits, zero-extended.
                    if (!PWRITE_i)   rdata_nxt   = DATA_W'(presc_q >> DATA_W);
                    else if (BUSY_i) err         = 1'b1;
                    else             presc_hi_we = 1'b1;
                end
                ADDR_W'(ADDR_CMD): begin
                    if (!PWRITE_i) begin
                        rdata_nxt[CMD_IRQ_EN_BIT] = irq_en_q;
                    end else begin
                        cmd_we = 1'b1;
                        // STOP takes priority; a START alongside it is dropped.
                        if (DATA_i[CMD_STOP_BIT]) begin
                            stop = 1'b1;
                        end else if (DATA_i[CMD_START_BIT]) begin
                            if (BUSY_i) err   = 1'b1;
                            else        start = 1'b1;
                        end
                    end
                end
                ADDR_W'(ADDR_ADDR_RW): begin
                    if (!PWRITE_i)   rdata_nxt  = ADDRESS_RW_o;
                    else if (BUSY_i) err        = 1'b1;
                    else             addr_rw_we = 1'b1;
                end
                ADDR_W'(ADDR_TRANSMIT): begin
                    if (PWRITE_i) begin
                        if (TX_FULL_i) begin
                            err        = 1'b1;
                            tx_ovf_set = 1'b1;
                        end else begin
                            tx_push = 1'b1;
                        end
                    end
                end
                ADDR_W'(ADDR_RECEIVE): begin
                    if (PWRITE_i) begin
                        err = 1'b1;
                    end else if (RX_EMPTY_i) begin
                        err        = 1'b1;
                        rx_udf_set = 1'b1;
                    end else begin
                        rdata_nxt = RECEIVE_i;
                        rx_pop    = 1'b1;
                    end
                end
                ADDR_W'(ADDR_STATUS): begin
                    if (PWRITE_i) stat_w1c  = DATA_i;
                    else          rdata_nxt = status;
                end
                ADDR_W'(ADDR_IRQ_MASK): begin
                    if (PWRITE_i) mask_we   = 1'b1;
                    else          rdata_nxt = mask_q;
                end
                ADDR_W'(ADDR_LEVEL): begin
                    if (PWRITE_i) begin
                        err = 1'b1;
                    end else begin
                        rdata_nxt[LVL_BUSY_BIT]     = BUSY_i;
                        rdata_nxt[LVL_RX_EMPTY_BIT] = RX_EMPTY_i;
                        rdata_nxt[LVL_TX_FULL_BIT]  = TX_FULL_i;
                    end
                end
                default: err = 1'b1;
            endcase
        end
    end

    always_comb begin
        stat_set                = '0;
        stat_set[NUM_EVT-1:0]   = STATUS_EVT_i;
        stat_set[STAT_OVF]      = tx_ovf_set;
        stat_set[STAT_UDF]      = rx_udf_set;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK_i or negedge RESET_i) begin
        if (!RESET_i) begin
            presc_q      <= PRESC_W'(PRESC_RST);
            ADDRESS_RW_o <= '0;
            mask_q       <= '0;
            irq_en_q     <= 1'b0;
            RDATA_o      <= '0;
            READY_o      <= 1'b0;
            SLVERR_o     <= 1'b0;
            RX_POP_o     <= 1'b0;
            TX_PUSH_o    <= 1'b0;
            TRANSMIT_o   <= '0;
            CMD_START_o  <= 1'b0;
            CMD_STOP_o   <= 1'b0;
        end else begin
            READY_o     <= SEL_i;
            SLVERR_o    <= err;
            RX_POP_o    <= rx_pop;
            TX_PUSH_o   <= tx_push;
            CMD_START_o <= start;
            CMD_STOP_o  <= stop;
            if (SEL_i && !PWRITE_i) RDATA_o <= rdata_nxt;
            if (tx_push)     TRANSMIT_o <= DATA_i;
            if (presc_lo_we) presc_q[DATA_W-1:0] <= DATA_i;
            if (presc_hi_we) presc_q[PRESC_W-1:DATA_W] <= DATA_i[HI_W-1:0];
            if (addr_rw_we)  ADDRESS_RW_o <= DATA_i;
            if (mask_we)     mask_q <= DATA_i;
            if (cmd_we)      irq_en_q <= DATA_i[CMD_IRQ_EN_BIT];
        end
    end

    assign PRESCALER_o = presc_q;

    i2c_sticky_status #(
        .DATA_W (DATA_W)
    ) u_status (
        .clk     (CLOCK_i),
        .rst_n   (RESET_i),
        .evt_set (stat_set),
        .w1c     (stat_w1c),
        .mask    (mask_q),
        .irq_en  (irq_en_q),
        .status  (status),
        .irq     (IRQ_o)
    );

endmodule

// File: tb/tb_i2c_reg_file.sv
// Scoreboard bench for i2c_reg_file: the driver updates a register-level
// model and queues the expected response of each access; a monitor pops
// and compares whenever READY_o is seen.
module tb_i2c_reg_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0, pwrite = 1'b0;
    logic [7:0]  addr = '0, wdata = '0;
    logic [7:0]  rdata;
    logic        ready, slverr;
    logic [7:0]  receive = '0;
    logic        rx_empty = 1'b1, tx_full = 1'b0;
    logic        rx_pop, tx_push;
    logic [7:0]  transmit;
    logic [5:0]  evt = '0;
    logic        busy = 1'b0;
    logic [15:0] prescaler;
    logic [7:0]  address_rw;
    logic        cmd_start, cmd_stop, irq;

    i2c_reg_file dut (
        .CLOCK_i         (clk),
        .RESET_i         (rst_n),
        .SEL_i           (sel),
        .PWRITE_i        (pwrite),
        .REGISTER_ADDR_i (addr),
        .DATA_i          (wdata),
        .RDATA_o         (rdata),
        .READY_o         (ready),
        .SLVERR_o        (slverr),
        .RECEIVE_i       (receive),
        .RX_EMPTY_i      (rx_empty),
        .TX_FULL_i       (tx_full),
        .RX_POP_o        (rx_pop),
        .TX_PUSH_o       (tx_push),
        .TRANSMIT_o      (transmit),
        .STATUS_EVT_i    (evt),
        .BUSY_i          (busy),
        .PRESCALER_o     (prescaler),
        .ADDRESS_RW_o    (address_rw),
        .CMD_START_o     (cmd_start),
        .CMD_STOP_o      (cmd_stop),
        .IRQ_o           (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         slverr;
        bit         is_rd;
        logic [7:0] rdata;
        bit         push, pop, start, stop;
        logic [7:0] tx;
    } exp_t;

    exp_t q_exp[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Register-level reference model
    int         m_presc;
    logic [7:0] m_addr_rw, m_mask, m_status, m_tx;
    bit         m_irq_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_presc   = 249;
        m_addr_rw = 0;
        m_mask    = 0;
        m_status  = 0;
        m_tx      = 0;
        m_irq_en  = 0;
        q_exp.delete();
    endtask

    task automatic idle_inputs();
        sel = 0; pwrite = 0; addr = 0; wdata = 0; evt = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        check("reset_prescaler", prescaler, 249);
        check("reset_irq", irq, 0);
        check("reset_address_rw", address_rw, 0);
    endtask

    // One clock cycle: drive inputs, predict, advance, check level outputs.
    task automatic cycle(input bit s, input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input logic [5:0] ev, input bit bsy, input bit txf, input bit rxe,
                         input logic [7:0] rxd);
        exp_t       e;
        bit         ovf, udf, irq_next, set_k;
        logic [7:0] clr;
        sel = s; pwrite = wr; addr = a; wdata = d; evt = ev;
        busy = bsy; tx_full = txf; rx_empty = rxe; receive = rxd;

        e = '{default: 0};
        ovf = 0; udf = 0; clr = 0;
        irq_next = m_irq_en && ((m_status & m_mask) != 0);
        if (s) begin
            e.is_rd = !wr;
            case (a)
                8'd0: if (!wr) e.rdata = 8'(m_presc % 256);
                      else if (bsy) e.slverr = 1;
                      else m_presc = (m_presc / 256) * 256 + int'(d);
                8'd1: if (!wr) e.rdata = 8'(m_presc / 256);
                      else if (bsy) e.slverr = 1;
                      else m_presc = int'(d) * 256 + (m_presc % 256);
                8'd2: if (!wr) e.rdata = m_irq_en ? 8'h04 : 8'h00;
                      else begin
                          m_irq_en = d[2];
                          if (d[1]) e.stop = 1;
                          else if (d[0]) begin
                              if (bsy) e.slverr = 1;
                              else e.start = 1;
                          end
                      end
                8'd3: if (!wr) e.rdata = m_addr_rw;
                      else if (bsy) e.slverr = 1;
                      else m_addr_rw = d;
                8'd4: if (wr) begin
                          if (txf) begin e.slverr = 1; ovf = 1; end
                          else begin e.push = 1; m_tx = d; end
                      end
                8'd5: if (wr) e.slverr = 1;
                      else if (rxe) begin e.slverr = 1; udf = 1; end
                      else begin e.rdata = rxd; e.pop = 1; end
                8'd6: if (wr) clr = d; else e.rdata = m_status;
                8'd7: if (wr) m_mask = d; else e.rdata = m_mask;
                8'd8: if (wr) e.slverr = 1;
                      else e.rdata = {5'b0, txf, rxe, bsy};
                default: e.slverr = 1;
            endcase
        end
        for (int k = 0; k < 8; k++) begin
            set_k = (k < 6 && ev[k]) || (k == 6 && ovf) || (k == 7 && udf);
            if (set_k) m_status[k] = 1'b1;
            else if (clr[k]) m_status[k] = 1'b0;
        end
        if (s) begin
            e.tx = m_tx;
            q_exp.push_back(e);
        end

        @(posedge clk);
        #1;
        check("irq", irq, irq_next);
        check("prescaler", prescaler, m_presc);
        check("address_rw", address_rw, m_addr_rw);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        cycle(1, 1, a, d, 0, busy, tx_full, rx_empty, receive);
    endtask

    task automatic rd_reg(input logic [7:0] a);
        cycle(1, 0, a, 0, 0, busy, tx_full, rx_empty, receive);
    endtask

    // Monitor: compare each registered response against the queued prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (ready) begin
                if (q_exp.size() == 0) begin
                    check("ready_unexpected", ready, 0);
                end else begin
                    mon_e = q_exp.pop_front();
                    check("slverr", slverr, mon_e.slverr);
                    check("tx_push", tx_push, mon_e.push);
                    check("rx_pop", rx_pop, mon_e.pop);
                    check("cmd_start", cmd_start, mon_e.start);
                    check("cmd_stop", cmd_stop, mon_e.stop);
                    check("transmit", transmit, mon_e.tx);
                    if (mon_e.is_rd) check("rdata", rdata, mon_e.rdata);
                end
            end else begin
                check("pulse_idle", {tx_push, rx_pop, cmd_start, cmd_stop, slverr}, 0);
            end
        end
    end

    initial begin
        model_reset();
        apply_reset();

        // Reset values
        rd_reg(8'h00);
        rd_reg(8'h01);
        rd_reg(8'h06);

        // Transmit: accepted then overflow, then STATUS shows TX_OVF
        cycle(1, 1, 8'h04, 8'hA5, 0, 0, 0, 1, 0);
        cycle(1, 1, 8'h04, 8'hA5, 0, 0, 1, 1, 0);
        cycle(1, 0, 8'h06, 0, 0, 0, 0, 1, 0);

        // Receive: pop then underflow, then STATUS shows RX_UDF
        cycle(1, 0, 8'h05, 0, 0, 0, 0, 0, 8'h3C);
        cycle(1, 0, 8'h05, 0, 0, 0, 0, 1, 8'h3C);
        cycle(1, 0, 8'h06, 0, 0, 0, 0, 1, 0);

        // Commands: START while busy, START idle, START+STOP
        cycle(1, 1, 8'h02, 8'h01, 0, 1, 0, 1, 0);
        cycle(1, 1, 8'h02, 8'h01, 0, 0, 0, 1, 0);
        cycle(1, 1, 8'h02, 8'h03, 0, 0, 0, 1, 0);

        // Interrupt path and set-wins-over-clear
        wr_reg(8'h07, 8'h01);
        wr_reg(8'h02, 8'h04);
        cycle(0, 0, 0, 0, 6'h01, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 1, 8'h06, 8'h01, 6'h01, 0, 0, 1, 0);
        rd_reg(8'h06);
        wr_reg(8'h06, 8'h01);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Prescaler high byte and reset during accesses
        cycle(1, 1, 8'h01, 8'h12, 0, 0, 0, 1, 0);
        check("presc_hi_write", prescaler, 16'h12F9);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);

        sel = 1; pwrite = 1; addr = 8'h01; wdata = 8'h77; busy = 0;
        #2 rst_n = 0;
        #1 check("mid_access_presc", prescaler, 249);
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        check("after_reset_presc", prescaler, 249);

        sel = 1; pwrite = 1; addr = 8'h00; wdata = 8'h55;
        @(posedge clk);
        #1 rst_n = 0;
        #1 check("ready_dropped", ready, 0);
        check("presc_reset_again", prescaler, 249);
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ra;
            logic [5:0] rev;
            ra  = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            rev = ($urandom_range(0, 7) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'h0;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra, 8'($urandom), rev,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, 8'($urandom));
        end

        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("scoreboard_drained", q_exp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
